// File: rtl/mm_stream_loader.sv
// mm_stream_loader: streams A/B words into flat operand buses, runs the control stage, streams C back out
module mm_stream_loader #(
  parameter int W = 32,
  parameter int N = 3,
  parameter int TIMEOUT = 64
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_mode,
  input  logic [W-1:0]     s_data,
  input  logic             s_valid,
  output logic             s_ready,
  output logic [W*N*N-1:0] o_A,
  output logic [W*N*N-1:0] o_B,
  output logic             o_en,
  output logic             o_mode,
  input  logic [W*N*N-1:0] i_C,
  input  logic             i_done,
  output logic [W-1:0]     m_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic             m_last,
  output logic             o_busy,
  output logic             o_err
);
  localparam int NN = N*N;
  localparam int CW = $clog2(2*NN);
  localparam int TW = $clog2(TIMEOUT+1);
  typedef enum logic [1:0] {LOAD, RUN, UNLOAD} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, slot;
  logic [TW-1:0] tcnt;
  logic [W*NN-1:0] c_buf;
  logic s_hs, m_hs, load_end, cap, tmo;
  always_comb begin
    s_ready = state == LOAD;
    m_valid = state == UNLOAD;
    m_last = m_valid && cnt == CW'(NN-1);
    m_data = c_buf[cnt*W +: W];
    o_busy = state != LOAD;
    s_hs = s_ready && s_valid;
    m_hs = m_valid && m_ready;
    load_end = s_hs && cnt == CW'(2*NN-1);
    cap = state == RUN && i_done;
    tmo = state == RUN && !i_done && tcnt == TW'(TIMEOUT-1);
    slot = cnt < CW'(NN) ? cnt : cnt - CW'(NN);
    state_n = load_end ? RUN : cap ? UNLOAD : (tmo || (m_hs && m_last)) ? LOAD : state;
  end
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) state <= LOAD;
    else state <= state_n;
  // cnt indexes the load slot in LOAD and the result word in UNLOAD
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt <= '0;
      tcnt <= '0;
      o_A <= '0;
      o_B <= '0;
      c_buf <= '0;
      o_en <= 1'b0;
      o_mode <= 1'b0;
      o_err <= 1'b0;
    end else begin
      o_en <= state_n == RUN;
      tcnt <= state == RUN ? tcnt + 1'b1 : '0;
      if (s_hs) begin
        if (cnt < CW'(NN)) o_A[slot*W +: W] <= s_data;
        else o_B[slot*W +: W] <= s_data;
        if (cnt == '0) begin
          o_mode <= i_mode;
          o_err <= 1'b0;
        end
      end
      if (cap) c_buf <= i_C;
      if (tmo) o_err <= 1'b1;
      cnt <= (load_end || (m_hs && m_last)) ? '0 : (s_hs || m_hs) ? cnt + 1'b1 : cnt;
    end
  end
endmodule

// File: tb/tb_mm_stream_loader.sv
// tb_mm_stream_loader: table-driven job vectors with a stub control stage and a result scoreboard
module tb_mm_stream_loader;
  localparam int W = 32, N = 3, NN = N*N, TIMEOUT = 64;
  logic i_clk = 0, i_rst = 0, i_mode = 0, s_valid = 0, i_done = 0, m_ready = 0;
  logic s_ready, o_en, o_mode, m_valid, m_last, o_busy, o_err;
  logic [W-1:0] s_data = '0, m_data;
  logic [W*NN-1:0] o_A, o_B, i_C = '0;
  typedef struct { bit mode, gaps, noise, exp_err; int dly, rdy, abase, bbase, cbase, exp_en, exp_hs; } vec_t;
  typedef struct { logic [W-1:0] d; logic l; } sb_t;
  sb_t sb[$];
  vec_t vt[6];
  vec_t rv, jv;
  int checks = 0, errors = 0, hs_cnt = 0, dly = 0, rdy = 0;
  bit noise = 0, prev_err = 0;

  mm_stream_loader #(.W(W), .N(N), .TIMEOUT(TIMEOUT)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_mode(i_mode), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .o_A(o_A), .o_B(o_B), .o_en(o_en), .o_mode(o_mode), .i_C(i_C), .i_done(i_done),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last), .o_busy(o_busy), .o_err(o_err)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // stub control stage: done after dly enabled cycles, optional spurious done while idle
  initial begin
    int rc = 0;
    bit real_d = 0, prev_real = 0;
    forever begin
      @(negedge i_clk);
      rc = o_en ? rc + 1 : 0;
      real_d = o_en && dly != 0 && rc == dly;
      i_done = real_d || (noise && !o_en && $urandom_range(0, 1) == 1);
      if (prev_real) i_C = ~i_C;
      prev_real = real_d;
    end
  end

  // result sink and scoreboard
  initial begin
    bit held = 0;
    logic [W-1:0] hd;
    logic hl;
    sb_t e;
    forever begin
      @(negedge i_clk);
      if (held) begin
        chk("hold_valid", m_valid, 1);
        chk("hold_data", m_data, hd);
        chk("hold_last", m_last, hl);
      end
      m_ready = rdy == 0 ? 1'b1 : rdy == 1 ? ~m_ready : 1'($urandom_range(0, 1));
      held = m_valid && !m_ready;
      hd = m_data;
      hl = m_last;
      if (m_valid && m_ready) begin
        hs_cnt++;
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_extra_word: got %0h, no word expected", m_data);
        end else begin
          e = sb.pop_front();
          chk("out_data", m_data, e.d);
          chk("out_last", m_last, e.l);
        end
      end
    end
  end

  task automatic load_job(input vec_t v);
    int idx = 0, cyc = 0;
    bit seen = 0;
    hs_cnt = 0;
    dly = v.dly;
    rdy = v.rdy;
    noise = v.noise;
    i_mode = v.mode;
    for (int k = 0; k < NN; k++) i_C[k*W +: W] = W'(v.cbase + k);
    if (!v.exp_err) for (int k = 0; k < NN; k++) sb.push_back('{W'(v.cbase + k), k == NN-1});
    chk("err_pre", o_err, prev_err);
    while (idx < 2*NN && cyc < 400) begin
      @(negedge i_clk);
      cyc++;
      if (idx == 1 && !seen) begin
        seen = 1;
        chk("err_clear", o_err, 0);
        chk("mode_latch", o_mode, v.mode);
        i_mode = ~v.mode;
      end
      s_valid = v.gaps ? $urandom_range(0, 2) != 0 : 1'b1;
      s_data = idx < NN ? W'(v.abase + idx) : W'(v.bbase + idx - NN);
      if (s_valid && s_ready) idx++;
    end
    chk("load_words", idx, 2*NN);
    if (!v.gaps) chk("load_cycles", cyc, 2*NN);
    chk("en_pre", o_en, 0);
    @(negedge i_clk);
    s_valid = 0;
    chk("en_rise", o_en, 1);
    chk("s_ready_run", s_ready, 0);
    chk("mode_run", o_mode, v.mode);
    for (int k = 0; k < NN; k++) begin
      chk("pack_A", o_A[k*W +: W], W'(v.abase + k));
      chk("pack_B", o_B[k*W +: W], W'(v.bbase + k));
    end
  endtask

  task automatic finish_job(input vec_t v);
    int en_c = 1, cyc = 0;
    bit mode_ok = 1, pen = 1;
    while (o_busy && cyc < 400) begin
      @(negedge i_clk);
      cyc++;
      if (o_en) begin
        en_c++;
        mode_ok &= o_mode == v.mode;
      end
      if (pen && !o_en) begin
        chk("valid_after_run", m_valid, !v.exp_err);
        chk("err_after_run", o_err, v.exp_err);
      end
      pen = o_en;
    end
    chk("busy_clear", o_busy, 0);
    chk("en_cycles", en_c, v.exp_en);
    chk("mode_hold", mode_ok, 1);
    chk("handshakes", hs_cnt, v.exp_hs);
    chk("sb_empty", sb.size(), 0);
    chk("s_ready_back", s_ready, 1);
    chk("m_valid_idle", m_valid, 0);
    chk("err_final", o_err, v.exp_err);
    chk("hold_A", o_A[0 +: W], W'(v.abase));
    chk("hold_B", o_B[(NN-1)*W +: W], W'(v.bbase + NN - 1));
    prev_err = v.exp_err;
    sb.delete();
  endtask

  initial begin
    //          mode gaps noise err dly rdy abase bbase cbase exp_en exp_hs
    vt[0] = '{0, 0, 0, 0,  5, 0,   1,  10, 100,  5, NN};
    vt[1] = '{1, 0, 0, 0,  3, 1, 200, 300, 400,  3, NN};
    vt[2] = '{0, 0, 0, 1,  0, 0,  17,  33,  49, 64, 0};
    vt[3] = '{0, 0, 0, 0,  1, 2,  50,  60,  70,  1, NN};
    vt[4] = '{0, 1, 1, 0, 64, 2,   1,  10, 500, 64, NN};
    vt[5] = '{1, 0, 0, 1, 65, 0,  80,  90, 600, 64, 0};
    rv = '{0, 0, 0, 1, 0, 0, 7, 8, 9, 0, 0};
    jv = '{1, 0, 0, 0, 4, 2, 20, 30, 40, 4, NN};
    #1 i_rst = 1;
    repeat (2) @(negedge i_clk);
    chk("rst_en", o_en, 0);
    chk("rst_A", o_A == '0, 1);
    chk("rst_B", o_B == '0, 1);
    chk("rst_mode", o_mode, 0);
    chk("rst_valid", m_valid, 0);
    chk("rst_last", m_last, 0);
    chk("rst_err", o_err, 0);
    chk("rst_busy", o_busy, 0);
    i_rst = 0;
    @(negedge i_clk);
    chk("rst_s_ready", s_ready, 1);
    for (int i = 0; i < 6; i++) begin
      load_job(vt[i]);
      finish_job(vt[i]);
    end
    load_job(rv);
    repeat (10) @(negedge i_clk);
    chk("arst_pre_en", o_en, 1);
    #2 i_rst = 1;
    #1;
    chk("arst_en", o_en, 0);
    chk("arst_A", o_A == '0, 1);
    chk("arst_B", o_B == '0, 1);
    chk("arst_busy", o_busy, 0);
    #1 i_rst = 0;
    prev_err = 0;
    @(negedge i_clk);
    chk("arst_s_ready", s_ready, 1);
    load_job(jv);
    finish_job(jv);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
